// File: rtl/fmm_reduce_kernel_ram_stream_reader.sv
// Streams a contiguous window of a 1R1W block RAM out on a valid/ready stream under ap_* block control.
// Optional running checksum of accepted beats is built when FMM_READER_CHECKSUM_EN is defined.
module fmm_reduce_kernel_ram_stream_reader #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 17,
  parameter int unsigned AddressRange = 102400
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ap_start,
  input  logic [AddressWidth-1:0] base,
  input  logic [AddressWidth:0]   count,
  output logic                    ap_idle,
  output logic                    ap_done,
  output logic                    ap_ready,
  output logic [AddressWidth-1:0] address0,
  output logic                    ce0,
  output logic                    we0,
  input  logic [DataWidth-1:0]    q0,
  output logic [DataWidth-1:0]    out_tdata,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic                    out_tlast,
  output logic [DataWidth-1:0]    checksum
);

  localparam int unsigned CountWidth = AddressWidth + 1;
  localparam logic [AddressWidth-1:0] LastAddr = AddressWidth'(AddressRange - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [CountWidth-1:0]   rd_left;
  logic                    q_vld;
  logic                    q_last;
  logic [1:0]              occ;
  logic [DataWidth-1:0]    tail_data;
  logic                    tail_last;

  logic                    start_acc_c;
  logic                    pop_c;
  logic                    issue_c;
  logic [1:0]              pending_c;
  logic [1:0]              occ_d;
  logic [DataWidth-1:0]    head_data_d;
  logic                    head_last_d;
  logic [DataWidth-1:0]    tail_data_d;
  logic                    tail_last_d;

  // Issue credit: the q0 stage plus the buffer never hold more than two words.
  // ce0 must see this cycle's pop, so the issue decision is combinational.
  assign start_acc_c = (state == S_IDLE) && ap_start;
  assign pop_c       = out_tvalid && out_tready;
  assign pending_c   = occ + {1'b0, q_vld};
  assign issue_c     = (state == S_RUN) && (rd_left != '0)
                       && ((pending_c - {1'b0, pop_c}) < 2'd2);

  assign ce0      = issue_c;
  assign we0      = 1'b0;

  // Control FSM, read address and issue counter.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= S_IDLE;
      ap_idle  <= 1'b1;
      ap_done  <= 1'b0;
      ap_ready <= 1'b0;
      rd_left  <= '0;
      address0 <= '0;
    end else begin
      ap_done  <= 1'b0;
      ap_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            rd_left  <= count;
            address0 <= base;
            ap_idle  <= 1'b0;
            if (count == '0) begin
              state    <= S_DONE;
              ap_done  <= 1'b1;
              ap_ready <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (issue_c) begin
            rd_left  <= rd_left - CountWidth'(1);
            address0 <= (address0 == LastAddr) ? '0 : address0 + AddressWidth'(1);
          end
          if (pop_c && out_tlast) begin
            state    <= S_DONE;
            ap_done  <= 1'b1;
            ap_ready <= 1'b1;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          ap_idle <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          ap_idle <= 1'b1;
        end
      endcase
    end
  end

  // q0 capture stage: tracks which cycle carries valid RAM data.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      q_vld  <= 1'b0;
      q_last <= 1'b0;
    end else begin
      q_vld  <= issue_c;
      q_last <= issue_c && (rd_left == CountWidth'(1));
    end
  end

  // Two-entry FIFO: pop shifts the tail forward, then a q0 word fills the first free slot.
  always_comb begin
    occ_d       = occ;
    head_data_d = out_tdata;
    head_last_d = out_tlast;
    tail_data_d = tail_data;
    tail_last_d = tail_last;
    if (pop_c) begin
      head_data_d = tail_data;
      head_last_d = tail_last;
      occ_d       = occ - 2'd1;
    end
    if (q_vld) begin
      if (occ_d == 2'd0) begin
        head_data_d = q0;
        head_last_d = q_last;
      end else begin
        tail_data_d = q0;
        tail_last_d = q_last;
      end
      occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      occ        <= '0;
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tlast  <= 1'b0;
      tail_data  <= '0;
      tail_last  <= 1'b0;
    end else begin
      occ        <= occ_d;
      out_tvalid <= (occ_d != 2'd0);
      out_tdata  <= head_data_d;
      out_tlast  <= head_last_d;
      tail_data  <= tail_data_d;
      tail_last  <= tail_last_d;
    end
  end

`ifdef FMM_READER_CHECKSUM_EN
  // Running sum of accepted beats; holds after the job until the next start.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      checksum <= '0;
    end else if (start_acc_c) begin
      checksum <= '0;
    end else if (pop_c) begin
      checksum <= checksum + out_tdata;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_fmm_reduce_kernel_ram_stream_reader.sv
// Self-checking bench for fmm_reduce_kernel_ram_stream_reader: table-driven jobs, random jobs,
// a mid-job reset sequence, all checked against a window/scoreboard model of the stream.
module tb_fmm_reduce_kernel_ram_stream_reader;

  localparam int AR = 102400;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        ap_start = 1'b0;
  logic [16:0] base = '0;
  logic [17:0] count = '0;
  logic        ap_idle, ap_done, ap_ready;
  logic [16:0] address0;
  logic        ce0, we0;
  logic [31:0] q0 = '0;
  logic [31:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready = 1'b0;
  logic        out_tlast;
  logic [31:0] checksum;

  int total = 0;
  int bad = 0;
  logic [31:0] salt = '0;

  fmm_reduce_kernel_ram_stream_reader dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .base(base), .count(count),
    .ap_idle(ap_idle), .ap_done(ap_done), .ap_ready(ap_ready), .address0(address0),
    .ce0(ce0), .we0(we0), .q0(q0), .out_tdata(out_tdata), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .out_tlast(out_tlast), .checksum(checksum)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic logic [31:0] ram_word(input int a, input logic [31:0] s);
    return 32'(a) ^ s;
  endfunction

  // RAM model: one-cycle read latency
  always @(posedge ap_clk) if (ce0) q0 <= ram_word(int'(address0), salt);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          b;
    int          c;
    int          mode;       // 0: ready from pat[t%4], 1: random ready
    logic [3:0]  pat;
    int          inject;     // cycle of a spurious mid-job start, -1 none
    int          exp_first;  // expected relative cycles, -1 = not checked
    int          exp_last;
    int          exp_done;
    logic [31:0] salt;
  } vec_t;

  // Runs one job from the current posedge+1 phase; returns at posedge+1 of the cycle after ap_done.
  task automatic run_job(input vec_t v);
    int issued = 0, beats = 0, done_t = -1, first_t = -1, last_t = -1, wait_n = 0, budget;
    logic [31:0] sum = '0, prev_data = '0, exp_ck;
    logic prev_stall = 1'b0;
    budget = 4 * v.c + 40;
    while (!ap_idle && wait_n < 50) begin @(posedge ap_clk); #1; wait_n++; end
    check("idle_before_start", ap_idle, 1);
    salt = v.salt;
    for (int t = 0; t <= budget; t++) begin
      if (t == 0) begin
        ap_start = 1'b1; base = 17'(v.b); count = 18'(v.c);
      end else if (t == v.inject) begin
        ap_start = 1'b1; base = 17'((v.b + 333) % AR); count = 18'(v.c + 5);
      end else begin
        ap_start = 1'b0;
      end
      out_tready = (v.mode == 0) ? v.pat[t % 4] : 1'($urandom_range(0, 1));
      @(negedge ap_clk);
      if (t == 1) check("idle_low", ap_idle, 0);
      if (prev_stall) begin
        check("hold_valid", out_tvalid, 1);
        check("hold_data", out_tdata, prev_data);
      end
      if (ce0) begin
        check("addr", address0, 64'((v.b + issued) % AR));
        check("credit", ((issued - beats - ((out_tvalid && out_tready) ? 1 : 0)) <= 1), 1);
        issued++;
      end
      if (out_tvalid && first_t < 0) first_t = t;
      if (out_tvalid && out_tready) begin
        check("data", out_tdata, ram_word((v.b + beats) % AR, v.salt));
        check("last", out_tlast, (beats == v.c - 1));
        if (out_tlast) last_t = t;
        sum += out_tdata;
        beats++;
      end
      prev_stall = out_tvalid && !out_tready;
      prev_data  = out_tdata;
      if (ap_done) begin
        done_t = t;
        check("ready_with_done", ap_ready, 1);
      end
      @(posedge ap_clk); #1;
      if (done_t >= 0) break;
    end
    ap_start = 1'b0;
    check("done_seen", (done_t >= 0), 1);
    check("issue_count", issued, v.c);
    check("beat_count", beats, v.c);
    if (v.c == 0) check("no_valid", first_t, -1);
    if (v.exp_first >= 0) check("first_valid_cycle", first_t, v.exp_first);
    if (v.exp_last >= 0)  check("last_beat_cycle", last_t, v.exp_last);
    if (v.exp_done >= 0)  check("done_cycle", done_t, v.exp_done);
`ifdef FMM_READER_CHECKSUM_EN
    exp_ck = sum;
`else
    exp_ck = '0;
`endif
    check("idle_after_done", ap_idle, 1);
    check("done_pulse_width", ap_done, 0);
    check("checksum", checksum, exp_ck);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_idle"}, ap_idle, 1);
    check({tag, "_done"}, ap_done, 0);
    check({tag, "_ready"}, ap_ready, 0);
    check({tag, "_ce0"}, ce0, 0);
    check({tag, "_we0"}, we0, 0);
    check({tag, "_addr"}, address0, 0);
    check({tag, "_tvalid"}, out_tvalid, 0);
    check({tag, "_tdata"}, out_tdata, 0);
    check({tag, "_tlast"}, out_tlast, 0);
    check({tag, "_checksum"}, checksum, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t rv;
    vecs[0] = '{b: 0,      c: 4,  mode: 0, pat: 4'b1111, inject: -1, exp_first: 3,  exp_last: 6,  exp_done: 7,  salt: 32'h0};
    vecs[1] = '{b: 5,      c: 0,  mode: 0, pat: 4'b1111, inject: -1, exp_first: -1, exp_last: -1, exp_done: 1,  salt: 32'h0};
    vecs[2] = '{b: 102398, c: 4,  mode: 0, pat: 4'b1111, inject: -1, exp_first: 3,  exp_last: 6,  exp_done: 7,  salt: 32'h0};
    vecs[3] = '{b: 10,     c: 8,  mode: 0, pat: 4'b1001, inject: -1, exp_first: -1, exp_last: -1, exp_done: -1, salt: 32'h0};
    vecs[4] = '{b: 100,    c: 6,  mode: 0, pat: 4'b1111, inject: 3,  exp_first: 3,  exp_last: 8,  exp_done: 9,  salt: 32'h0};
    vecs[5] = '{b: 102399, c: 1,  mode: 0, pat: 4'b1111, inject: -1, exp_first: 3,  exp_last: 3,  exp_done: 4,  salt: 32'hA5A5_0000};
    vecs[6] = '{b: 102390, c: 17, mode: 0, pat: 4'b1111, inject: -1, exp_first: 3,  exp_last: 19, exp_done: 20, salt: 32'h1234_5678};

    repeat (2) @(posedge ap_clk);
    #1;
    check_reset_outputs("reset");
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    for (int i = 0; i < 12; i++) begin
      rv = '{b: int'($urandom % AR), c: int'($urandom_range(0, 24)), mode: 1, pat: 4'b0,
             inject: (($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 6)) : -1),
             exp_first: -1, exp_last: -1, exp_done: -1, salt: $urandom};
      run_job(rv);
    end

    // Mid-job asynchronous reset, then a fresh job.
    salt = '0;
    ap_start = 1'b1; base = 17'd50; count = 18'd10; out_tready = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    repeat (4) @(posedge ap_clk);
    #1;
    check("live_before_abort", out_tvalid, 1);
    #1;
    ap_rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge ap_clk); #1;
    check_reset_outputs("abort_held");
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    run_job('{b: 7, c: 2, mode: 0, pat: 4'b1111, inject: -1, exp_first: 3, exp_last: 4, exp_done: 5, salt: 32'h0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
